// File: rtl/fft_usb_pkg.sv
// Shared types for the FFT-to-USB framing path.
// Holds FSM state encodings and the buffered sample entry layout.
package fft_usb_pkg;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hA5A5;

  typedef enum logic [1:0] {
    IN_IDLE,
    IN_ACCEPT,
    IN_DROP
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_HDR,
    OUT_DATA
  } out_state_t;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } fifo_entry_t;

  localparam int ENTRY_W = $bits(fifo_entry_t);

  function automatic logic [31:0] hdr_word(
    input logic [15:0] sync,
    input logic [15:0] seq
  );
    return {sync, seq};
  endfunction

endpackage

// File: rtl/fft_frame_packer_if.sv
// Sample input and word output stream of the frame packer.
// master drives samples and ready; slave is the packer.
interface fft_frame_packer_if;

  logic [31:0] in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic [31:0] fdata;
  logic        sink_valid;
  logic        sink_ready;

  modport master (
    output in_data, in_valid, in_sop, in_eop,
    output sink_ready,
    input  fdata, sink_valid
  );

  modport slave (
    input  in_data, in_valid, in_sop, in_eop,
    input  sink_ready,
    output fdata, sink_valid
  );

endinterface

// File: rtl/fft_pkt_fifo.sv
// Single-clock FIFO with a registered show-ahead read stage.
// level counts every word not yet popped, including the read stage.
module fft_pkt_fifo #(
  parameter int W      = 34,
  parameter int ADDR_W = 11
) (
  input  logic            ifclk,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [W-1:0]    wr_data,
  input  logic            rd_en,
  output logic [W-1:0]    rd_data,
  output logic            rd_valid,
  output logic [ADDR_W:0] level
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [W-1:0]    mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            ram_empty;
  logic            pop;
  logic            fetch;

  assign ram_empty = (wr_ptr == rd_ptr);
  assign pop       = rd_en & rd_valid;
  // refill the read stage whenever it is empty or being consumed
  assign fetch     = !ram_empty & (!rd_valid | pop);

  always_ff @(posedge ifclk) begin
    if (wr_en) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge ifclk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      level    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fetch) begin
        rd_data  <= mem[rd_ptr[ADDR_W-1:0]];
        rd_ptr   <= rd_ptr + 1'b1;
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
      unique case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fft_frame_packer.sv
// Buffers whole FFT frames and emits them as header-prefixed word streams.
// Frames that cannot fit completely are dropped and counted.
module fft_frame_packer
  import fft_usb_pkg::*;
#(
  parameter int          FRAME_LEN = 1024,
  parameter int          ADDR_W    = 11,
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic                ifclk,
  input  logic                reset,
  fft_frame_packer_if.slave   io,
  output logic [15:0]         frame_drop_cnt,
  output logic                len_err,
  output logic [ADDR_W:0]     fifo_level
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST    = CNT_W'(FRAME_LEN);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0]   FLEN_L  = (ADDR_W + 1)'(FRAME_LEN);

  in_state_t        in_st;
  in_state_t        in_nxt;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_set;
  logic             drop_inc;
  logic             wr_en;
  fifo_entry_t      wr_entry;
  logic             space_ok;

  out_state_t       out_st;
  logic [31:0]      fdata_q;
  logic             valid_q;
  logic             cur_eop;
  logic [15:0]      seq;
  logic             xfer;
  logic             pop;
  logic             hv;
  logic [ENTRY_W-1:0] rd_raw;
  fifo_entry_t      head;

  fft_pkt_fifo #(
    .W      (ENTRY_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .ifclk    (ifclk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_entry),
    .rd_en    (pop),
    .rd_data  (rd_raw),
    .rd_valid (hv),
    .level    (fifo_level)
  );

  assign head      = fifo_entry_t'(rd_raw);
  assign space_ok  = (DEPTH_L - fifo_level) >= FLEN_L;
  assign xfer      = valid_q & io.sink_ready;
  assign io.fdata      = fdata_q;
  assign io.sink_valid = valid_q;

  always_comb begin
    in_nxt        = in_st;
    cnt_nxt       = wcnt;
    err_set       = 1'b0;
    drop_inc      = 1'b0;
    wr_en         = 1'b0;
    wr_entry      = '0;
    wr_entry.data = io.in_data;
    if (io.in_valid) begin
      if (io.in_sop) begin
        err_set = (in_st != IN_IDLE);
        if (space_ok) begin
          wr_en        = 1'b1;
          wr_entry.sop = 1'b1;
          cnt_nxt      = CNT_W'(1);
        end else begin
          drop_inc = 1'b1;
          in_nxt   = io.in_eop ? IN_IDLE : IN_DROP;
        end
      end else begin
        unique case (in_st)
          IN_ACCEPT: begin
            wr_en   = 1'b1;
            cnt_nxt = wcnt + 1'b1;
          end
          IN_DROP: begin
            if (io.in_eop) in_nxt = IN_IDLE;
          end
          default: ;
        endcase
      end
      // an over-long frame is closed at FRAME_LEN words
      if (wr_en) begin
        wr_entry.eop = io.in_eop | (cnt_nxt == LAST);
        if (io.in_eop) begin
          in_nxt = IN_IDLE;
        end else if (cnt_nxt == LAST) begin
          err_set = 1'b1;
          in_nxt  = IN_DROP;
        end else begin
          in_nxt = IN_ACCEPT;
        end
      end
    end
  end

  always_ff @(posedge ifclk) begin
    if (reset) begin
      in_st          <= IN_IDLE;
      wcnt           <= '0;
      len_err        <= 1'b0;
      frame_drop_cnt <= '0;
    end else begin
      in_st <= in_nxt;
      wcnt  <= cnt_nxt;
      if (err_set) begin
        len_err <= 1'b1;
      end
      if (drop_inc && frame_drop_cnt != 16'hFFFF) begin
        frame_drop_cnt <= frame_drop_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    pop = 1'b0;
    unique case (out_st)
      OUT_IDLE: pop = hv & !head.sop;
      OUT_HDR:  pop = xfer;
      OUT_DATA: pop = (!valid_q | xfer) & !(xfer & cur_eop)
                      & hv & !head.sop;
      default:  pop = 1'b0;
    endcase
  end

  always_ff @(posedge ifclk) begin
    if (reset) begin
      out_st  <= OUT_IDLE;
      fdata_q <= '0;
      valid_q <= 1'b0;
      cur_eop <= 1'b0;
      seq     <= '0;
    end else begin
      unique case (out_st)
        OUT_IDLE: begin
          if (hv && head.sop) begin
            fdata_q <= hdr_word(SYNC_WORD, seq);
            valid_q <= 1'b1;
            out_st  <= OUT_HDR;
          end
        end
        OUT_HDR: begin
          // the head still holds the sop word this header announced
          if (xfer) begin
            seq     <= seq + 1'b1;
            fdata_q <= head.data;
            cur_eop <= head.eop;
            out_st  <= OUT_DATA;
          end
        end
        OUT_DATA: begin
          if (xfer && cur_eop) begin
            valid_q <= 1'b0;
            cur_eop <= 1'b0;
            out_st  <= OUT_IDLE;
          end else if (!valid_q || xfer) begin
            if (!hv) begin
              valid_q <= 1'b0;
            end else if (head.sop) begin
              fdata_q <= hdr_word(SYNC_WORD, seq);
              valid_q <= 1'b1;
              cur_eop <= 1'b0;
              out_st  <= OUT_HDR;
            end else begin
              fdata_q <= head.data;
              cur_eop <= head.eop;
              valid_q <= 1'b1;
            end
          end
        end
        default: out_st <= OUT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_packer.sv
// Scoreboard bench for fft_frame_packer with FRAME_LEN=8, ADDR_W=4.
// Stimulus pushes expected words; a negedge monitor pops and compares.
module tb_fft_frame_packer;

  localparam int FL = 8;
  localparam int AW = 4;

  logic          ifclk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   frame_drop_cnt;
  logic          len_err;
  logic [AW:0]   fifo_level;

  fft_frame_packer_if io();

  fft_frame_packer #(
    .FRAME_LEN (FL),
    .ADDR_W    (AW),
    .SYNC_WORD (16'hA5A5)
  ) dut (
    .ifclk          (ifclk),
    .reset          (reset),
    .io             (io),
    .frame_drop_cnt (frame_drop_cnt),
    .len_err        (len_err),
    .fifo_level     (fifo_level)
  );

  always #5 ifclk = ~ifclk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          xfer_cnt = 0;
  int          cyc      = 0;
  int          mode     = 0;
  logic [31:0] exp_q[$];
  logic        hold     = 1'b0;
  logic [31:0] held     = '0;
  logic [31:0] exp_v;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  // mode 0: ready always, 1: ready one cycle in three, 2: never ready
  initial begin
    io.sink_ready = 1'b0;
    forever begin
      @(posedge ifclk); #1;
      cyc++;
      case (mode)
        0:       io.sink_ready = 1'b1;
        1:       io.sink_ready = (cyc % 3 == 0);
        default: io.sink_ready = 1'b0;
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge ifclk);
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          chk("hold_valid", {31'd0, io.sink_valid}, 32'd1);
          chk("hold_data", io.fdata, held);
        end
        if (io.sink_valid && io.sink_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL extra_word: got %h expected none", io.fdata);
          end else begin
            exp_v = exp_q.pop_front();
            chk("fdata", io.fdata, exp_v);
          end
          xfer_cnt++;
        end
        hold = io.sink_valid && !io.sink_ready;
        held = io.fdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic put(input logic [31:0] d, input logic s, input logic e);
    io.in_data  = d;
    io.in_valid = 1'b1;
    io.in_sop   = s;
    io.in_eop   = e;
    @(posedge ifclk); #1;
    io.in_valid = 1'b0;
    io.in_sop   = 1'b0;
    io.in_eop   = 1'b0;
  endtask

  task automatic send(input logic [31:0] base, input int n);
    for (int i = 1; i <= n; i++) put(base + i, i == 1, i == n);
  endtask

  task automatic expect_frame(input logic [15:0] sq,
                              input logic [31:0] base, input int n);
    exp_q.push_back({16'hA5A5, sq});
    for (int i = 1; i <= n; i++) exp_q.push_back(base + i);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge ifclk);
      n++;
    end
    chk(nm, exp_q.size(), 32'd0);
    repeat (6) @(posedge ifclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge ifclk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int base_x;
    io.in_data  = '0;
    io.in_valid = 1'b0;
    io.in_sop   = 1'b0;
    io.in_eop   = 1'b0;
    repeat (3) @(posedge ifclk);
    #1;
    chk("rst_valid", {31'd0, io.sink_valid}, 32'd0);
    chk("rst_fdata", io.fdata, 32'd0);
    chk("rst_level", {27'd0, fifo_level}, 32'd0);
    chk("rst_drop", {16'd0, frame_drop_cnt}, 32'd0);
    chk("rst_lenerr", {31'd0, len_err}, 32'd0);
    reset = 1'b0;

    // single frame, ready held high, header latency
    mode = 0;
    expect_frame(16'h0000, 32'd0, 8);
    put(32'd1, 1'b1, 1'b0);
    put(32'd2, 1'b0, 1'b0);
    chk("lat_t1_valid", {31'd0, io.sink_valid}, 32'd0);
    put(32'd3, 1'b0, 1'b0);
    chk("lat_t2_valid", {31'd0, io.sink_valid}, 32'd1);
    chk("lat_t2_hdr", io.fdata, 32'hA5A50000);
    for (int i = 4; i <= 8; i++) put(i, 1'b0, i == 8);
    drain("t1_drain");
    chk("t1_idle_valid", {31'd0, io.sink_valid}, 32'd0);
    chk("t1_level", {27'd0, fifo_level}, 32'd0);
    chk("t1_lenerr", {31'd0, len_err}, 32'd0);

    // same frame with sparse ready
    do_reset();
    mode = 1;
    expect_frame(16'h0000, 32'd0, 8);
    send(32'd0, 8);
    drain("t2_drain");

    // three frames while blocked: third does not fit
    do_reset();
    mode = 2;
    expect_frame(16'h0000, 32'h100, 8);
    expect_frame(16'h0001, 32'h200, 8);
    send(32'h100, 8);
    send(32'h200, 8);
    send(32'h300, 8);
    repeat (2) @(posedge ifclk);
    #1;
    chk("t3_level", {27'd0, fifo_level}, 32'd16);
    chk("t3_drop", {16'd0, frame_drop_cnt}, 32'd1);
    mode = 0;
    drain("t3_drain");
    chk("t3_drop_after", {16'd0, frame_drop_cnt}, 32'd1);
    chk("t3_level_after", {27'd0, fifo_level}, 32'd0);

    // over-long frame closed at FRAME_LEN
    do_reset();
    mode = 0;
    expect_frame(16'h0000, 32'h400, 8);
    send(32'h400, 10);
    drain("t4_drain");
    chk("t4_lenerr", {31'd0, len_err}, 32'd1);
    chk("t4_level", {27'd0, fifo_level}, 32'd0);

    // reset in the middle of an output frame
    do_reset();
    mode = 1;
    expect_frame(16'h0000, 32'h500, 8);
    base_x = xfer_cnt;
    send(32'h500, 8);
    n = 0;
    while (xfer_cnt < base_x + 3 && n < 200) begin
      @(posedge ifclk);
      n++;
    end
    chk("t5_progress", {31'd0, xfer_cnt >= base_x + 3}, 32'd1);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge ifclk);
    #1;
    chk("t5_valid", {31'd0, io.sink_valid}, 32'd0);
    chk("t5_level", {27'd0, fifo_level}, 32'd0);
    reset = 1'b0;
    mode = 0;
    expect_frame(16'h0000, 32'h600, 8);
    send(32'h600, 8);
    drain("t5_drain");

    // stray samples outside a frame
    do_reset();
    put(32'h71, 1'b0, 1'b0);
    put(32'h72, 1'b0, 1'b0);
    put(32'h73, 1'b0, 1'b1);
    repeat (4) @(posedge ifclk);
    #1;
    chk("t6_level", {27'd0, fifo_level}, 32'd0);
    chk("t6_valid", {31'd0, io.sink_valid}, 32'd0);
    chk("t6_lenerr", {31'd0, len_err}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
